// File: rtl/asp_irq_pkg.sv
// Shared definitions for the ASP interrupt responder.
//
// Contents:
//   - BSP interrupt line assignments and the line count.
//   - CSR word addresses inside the MMIO64 window, and the ID constant.
//   - Host-side FSM state enum.
//
// Optional build macro used by the responder: ASP_IRQ_EDGE_DETECT_EN.
package asp_irq_pkg;

    // Board-level interrupt line map
    localparam int BSP_NUM_INTERRUPT_LINES = 4;
    localparam int BSP_DMA_0_IRQ_BIT       = 0;
    localparam int BSP_KERNEL_IRQ_BIT      = 1;
    localparam int BSP_DMA_1_IRQ_BIT       = 2;

    localparam int IRQ_BIT_DMA_0  = BSP_DMA_0_IRQ_BIT;
    localparam int IRQ_BIT_KERNEL = BSP_KERNEL_IRQ_BIT;
    localparam int IRQ_BIT_DMA_1  = BSP_DMA_1_IRQ_BIT;

    // CSR word addresses
    localparam int CSR_STATUS  = 0;
    localparam int CSR_PENDING = 1;
    localparam int CSR_ENABLE  = 2;
    localparam int CSR_EOI     = 3;
    localparam int CSR_COUNT   = 4;
    localparam int CSR_ID      = 5;

    localparam logic [63:0] CSR_ID_VALUE = 64'h4153_5049_5251_0001;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        SERVICED = 2'd2
    } irq_state_e;

endpackage

// File: rtl/asp_irq_prio_enc.sv
// Lowest-set-bit priority encoder.
//
// Ports:
//   req    in  NUM_IRQ           request vector
//   vector out IRQ_VECTOR_WIDTH  index of the lowest set bit (0 when none set)
module asp_irq_prio_enc #(
    parameter int NUM_IRQ          = 4,
    parameter int IRQ_VECTOR_WIDTH = 2
) (
    input  logic [NUM_IRQ-1:0]          req,
    output logic [IRQ_VECTOR_WIDTH-1:0] vector
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        vector = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                vector = IRQ_VECTOR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/asp_irq_responder.sv
// ASP interrupt responder: latches interrupt lines into a 64-bit CSR block
// (AVMM responder, fixed 2-cycle read latency) and raises a single host
// interrupt request with a vector, held off until the host writes EOI.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   irq_in                interrupt sources (synchronous to clk)
//   avmm_*                AVMM responder (address, read, write, writedata,
//                         byteenable, readdata, readdatavalid, waitrequest)
//   host_irq_req/_vector  host interrupt request and lowest pending line
//   host_irq_ack          host accepts the request
//
// Build option: ASP_IRQ_EDGE_DETECT_EN selects rising-edge capture of irq_in
// (one input register); undefined selects level capture.
module asp_irq_responder
    import asp_irq_pkg::*;
#(
    parameter int NUM_IRQ          = BSP_NUM_INTERRUPT_LINES,
    parameter int CSR_ADDR_WIDTH   = 3,
    parameter int IRQ_VECTOR_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_IRQ-1:0]          irq_in,
    input  logic [CSR_ADDR_WIDTH-1:0]   avmm_address,
    input  logic                        avmm_read,
    input  logic                        avmm_write,
    input  logic [63:0]                 avmm_writedata,
    input  logic [7:0]                  avmm_byteenable,
    output logic [63:0]                 avmm_readdata,
    output logic                        avmm_readdatavalid,
    output logic                        avmm_waitrequest,
    output logic                        host_irq_req,
    output logic [IRQ_VECTOR_WIDTH-1:0] host_irq_vector,
    input  logic                        host_irq_ack
);

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_STATUS  = CSR_ADDR_WIDTH'(CSR_STATUS);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_PENDING = CSR_ADDR_WIDTH'(CSR_PENDING);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_ENABLE  = CSR_ADDR_WIDTH'(CSR_ENABLE);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_EOI     = CSR_ADDR_WIDTH'(CSR_EOI);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_COUNT   = CSR_ADDR_WIDTH'(CSR_COUNT);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_ID      = CSR_ADDR_WIDTH'(CSR_ID);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic                        waitreq_q;
    logic                        rd_en;
    logic                        wr_en;
    logic                        wr_pending;
    logic                        wr_enable;
    logic                        wr_eoi;
    logic [NUM_IRQ-1:0]          be_mask;
    logic [NUM_IRQ-1:0]          set_vec;
    logic [NUM_IRQ-1:0]          w1c_vec;
    logic [NUM_IRQ-1:0]          pending_q;
    logic [NUM_IRQ-1:0]          enable_q;
    logic [NUM_IRQ-1:0]          active_vec;
    logic                        active;
    logic [31:0]                 count_q;
    irq_state_e                  state_q;
    irq_state_e                  state_n;
    logic                        latch_vec;
    logic                        bump_count;
    logic [IRQ_VECTOR_WIDTH-1:0] vec_enc;
    logic [IRQ_VECTOR_WIDTH-1:0] vec_q;
    logic [63:0]                 rd_mux;
    logic [63:0]                 rdata_p0;
    logic [63:0]                 rdata_p1;
    logic                        vld_p0;
    logic                        vld_p1;
    logic                        unused_bits;

    // Upper write-data bits and unused byte enables carry no state.
    assign unused_bits = ^{avmm_writedata, avmm_byteenable};

    // Commands are not accepted while the block is still coming out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) waitreq_q <= 1'b1;
        else       waitreq_q <= 1'b0;
    end

    assign avmm_waitrequest = waitreq_q;
    assign rd_en = avmm_read  & ~waitreq_q;
    assign wr_en = avmm_write & ~waitreq_q;

    assign wr_pending = wr_en && (avmm_address == ADDR_PENDING);
    assign wr_enable  = wr_en && (avmm_address == ADDR_ENABLE);
    assign wr_eoi     = wr_en && (avmm_address == ADDR_EOI) && avmm_byteenable[0];

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_be
        assign be_mask[i] = avmm_byteenable[i/8];
    end

    assign w1c_vec = wr_pending ? (avmm_writedata[NUM_IRQ-1:0] & be_mask) : '0;

`ifdef ASP_IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] irq_p0;
    logic [NUM_IRQ-1:0] irq_p1;

    // ---- input register / edge history ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_p0 <= '0;
            irq_p1 <= '0;
        end else begin
            irq_p0 <= irq_in;
            irq_p1 <= irq_p0;
        end
    end

    assign set_vec = irq_p0 & ~irq_p1;
`else
    assign set_vec = irq_in;
`endif

    // Set has priority over a same-cycle W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            enable_q  <= '0;
        end else begin
            pending_q <= (pending_q & ~w1c_vec) | set_vec;
            if (wr_enable) begin
                enable_q <= (enable_q & ~be_mask) | (avmm_writedata[NUM_IRQ-1:0] & be_mask);
            end
        end
    end

    assign active_vec = pending_q & enable_q;
    assign active     = |active_vec;

    asp_irq_prio_enc #(
        .NUM_IRQ          (NUM_IRQ),
        .IRQ_VECTOR_WIDTH (IRQ_VECTOR_WIDTH)
    ) u_prio_enc (
        .req    (active_vec),
        .vector (vec_enc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // A raised request is never retracted: REQ waits for ack even if the
    // source was cleared or masked meanwhile.
    always_comb begin
        state_n      = state_q;
        latch_vec    = 1'b0;
        bump_count   = 1'b0;
        host_irq_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (active) begin
                    state_n   = REQ;
                    latch_vec = 1'b1;
                end
            end
            REQ: begin
                host_irq_req = 1'b1;
                if (host_irq_ack) begin
                    state_n    = SERVICED;
                    bump_count = 1'b1;
                end
            end
            SERVICED: begin
                if (wr_eoi) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_q   <= '0;
            count_q <= '0;
        end else begin
            if (latch_vec)  vec_q   <= vec_enc;
            if (bump_count) count_q <= sat_inc(count_q);
        end
    end

    assign host_irq_vector = vec_q;

    // Read mux sees pre-write register values, so a same-cycle write is
    // not visible to the read.
    always_comb begin
        rd_mux = '0;
        case (avmm_address)
            ADDR_STATUS:  rd_mux[NUM_IRQ-1:0] = active_vec;
            ADDR_PENDING: rd_mux[NUM_IRQ-1:0] = pending_q;
            ADDR_ENABLE:  rd_mux[NUM_IRQ-1:0] = enable_q;
            ADDR_COUNT:   rd_mux[31:0]        = count_q;
            ADDR_ID:      rd_mux              = CSR_ID_VALUE;
            default:      rd_mux              = '0;
        endcase
    end

    // ---- read stage p0: capture command ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            rdata_p0 <= '0;
        end else begin
            vld_p0   <= rd_en;
            rdata_p0 <= rd_mux;
        end
    end

    // ---- read stage p1: response ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1   <= vld_p0;
            rdata_p1 <= rdata_p0;
        end
    end

    assign avmm_readdata      = rdata_p1;
    assign avmm_readdatavalid = vld_p1;

endmodule

// File: tb/tb_asp_irq_responder.sv
// Self-checking bench for asp_irq_responder: directed scenarios followed by
// randomized traffic, checked by a scoreboard against a behavioural model.
module tb_asp_irq_responder;

    localparam logic [63:0] ID_VAL = 64'h4153_5049_5251_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq_in = '0;
    logic [2:0]  avmm_address = '0;
    logic        avmm_read = 1'b0;
    logic        avmm_write = 1'b0;
    logic [63:0] avmm_writedata = '0;
    logic [7:0]  avmm_byteenable = '0;
    logic [63:0] avmm_readdata;
    logic        avmm_readdatavalid;
    logic        avmm_waitrequest;
    logic        host_irq_req;
    logic [1:0]  host_irq_vector;
    logic        host_irq_ack = 1'b0;

    always #5 clk = ~clk;

    asp_irq_responder dut (
        .clk                (clk),
        .reset              (reset),
        .irq_in             (irq_in),
        .avmm_address       (avmm_address),
        .avmm_read          (avmm_read),
        .avmm_write         (avmm_write),
        .avmm_writedata     (avmm_writedata),
        .avmm_byteenable    (avmm_byteenable),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid),
        .avmm_waitrequest   (avmm_waitrequest),
        .host_irq_req       (host_irq_req),
        .host_irq_vector    (host_irq_vector),
        .host_irq_ack       (host_irq_ack)
    );

    int compared   = 0;
    int mismatched = 0;
    int edge_no    = 0;
    bit in_reset   = 1'b1;

    typedef struct {
        logic [63:0] data;
        int          due;
        int          addr;
    } rd_exp_t;
    rd_exp_t rq[$];

    // Behavioural model state (value after the most recent clock edge)
    logic [3:0]  m_pend  = '0;
    logic [3:0]  m_en    = '0;
    logic [31:0] m_count = '0;
    bit          m_req   = 1'b0;   // host request raised, awaiting ack
    bit          m_wait  = 1'b0;   // acked, awaiting EOI
    logic [1:0]  m_vec   = '0;
    logic [3:0]  m_seen1 = '0;     // irq_in seen at the previous edge
    logic [3:0]  m_seen2 = '0;     // irq_in seen two edges ago

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {60'd0, m_pend & m_en};
            3'd1:    return {60'd0, m_pend};
            3'd2:    return {60'd0, m_en};
            3'd4:    return {32'd0, m_count};
            3'd5:    return ID_VAL;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic void model_clear();
        m_pend = '0; m_en = '0; m_count = '0;
        m_req = 1'b0; m_wait = 1'b0; m_vec = '0;
        m_seen1 = '0; m_seen2 = '0;
    endfunction

    // Predict the effect of the coming clock edge given the driven inputs.
    task automatic model_update();
        logic [3:0] setv, be_m, w1c;
        bit active, eoi;
        for (int i = 0; i < 4; i++) be_m[i] = avmm_byteenable[i/8];
        if (avmm_read) begin
            rd_exp_t e;
            e.data = model_read(avmm_address);
            e.due  = edge_no + 2;
            e.addr = int'(avmm_address);
            rq.push_back(e);
        end
        active = |(m_pend & m_en);
        eoi    = avmm_write && avmm_address == 3'd3 && avmm_byteenable[0];
`ifdef ASP_IRQ_EDGE_DETECT_EN
        setv    = m_seen1 & ~m_seen2;
        m_seen2 = m_seen1;
        m_seen1 = irq_in;
`else
        setv = irq_in;
`endif
        w1c = (avmm_write && avmm_address == 3'd1) ? (avmm_writedata[3:0] & be_m) : 4'd0;
        if (m_req) begin
            if (host_irq_ack) begin
                m_req  = 1'b0;
                m_wait = 1'b1;
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            end
        end else if (m_wait) begin
            if (eoi) m_wait = 1'b0;
        end else if (active) begin
            m_req = 1'b1;
            m_vec = lowest(m_pend & m_en);
        end
        m_pend = (m_pend & ~w1c) | setv;
        if (avmm_write && avmm_address == 3'd2)
            m_en = (m_en & ~be_m) | (avmm_writedata[3:0] & be_m);
    endtask

    // Monitor: samples 1 time unit after each rising edge
    always @(posedge clk) begin
        edge_no++;
        #1;
        if (!in_reset) begin
            check("waitrequest_low", 64'(avmm_waitrequest), 64'd0);
            if (avmm_readdatavalid) begin
                if (rq.size() == 0) begin
                    check("unexpected_readdatavalid", 64'd1, 64'd0);
                end else begin
                    rd_exp_t e;
                    e = rq.pop_front();
                    check($sformatf("readdata_addr%0d", e.addr), avmm_readdata, e.data);
                    check("read_latency_edge", 64'(edge_no), 64'(e.due));
                end
            end else if (rq.size() > 0 && rq[0].due <= edge_no) begin
                rd_exp_t e;
                e = rq.pop_front();
                check($sformatf("missing_readdatavalid_addr%0d", e.addr), 64'd0, 64'd1);
            end
            check("host_irq_req", 64'(host_irq_req), 64'(m_req));
            if (m_req) check("host_irq_vector", 64'(host_irq_vector), 64'(m_vec));
        end
    end

    task automatic step();
        model_update();
        @(negedge clk);
        avmm_read       = 1'b0;
        avmm_write      = 1'b0;
        avmm_address    = '0;
        avmm_writedata  = '0;
        avmm_byteenable = '0;
        host_irq_ack    = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [63:0] d, input logic [7:0] be);
        avmm_write = 1'b1; avmm_address = a; avmm_writedata = d; avmm_byteenable = be;
        step();
    endtask

    task automatic rd(input logic [2:0] a);
        avmm_read = 1'b1; avmm_address = a;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!host_irq_req && n < 20) begin
            step();
            n++;
        end
        check({name, "_req_seen"}, 64'(host_irq_req), 64'd1);
    endtask

    task automatic ack();
        host_irq_ack = 1'b1;
        step();
    endtask

    task automatic eoi();
        wr(3'd3, 64'd1, 8'h01);
    endtask

    // Called at a falling edge; reset takes effect asynchronously.
    task automatic apply_reset();
        reset    = 1'b1;
        in_reset = 1'b1;
        #1;
        check("reset_host_irq_req", 64'(host_irq_req), 64'd0);
        check("reset_host_irq_vector", 64'(host_irq_vector), 64'd0);
        check("reset_waitrequest", 64'(avmm_waitrequest), 64'd1);
        check("reset_readdatavalid", 64'(avmm_readdatavalid), 64'd0);
        check("reset_readdata", avmm_readdata, 64'd0);
        model_clear();
        rq.delete();
        irq_in = '0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        in_reset = 1'b0;
        step();
    endtask

    initial begin
        @(negedge clk);
        apply_reset();

        // Reset values and ID
        rd(3'd5); rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd4);
        idle(3);

        // Single interrupt on the kernel line
        wr(3'd2, 64'h2, 8'h01);
        irq_in = 4'b0010; step();
        irq_in = 4'b0000;
        wait_req("t2");
        check("t2_vector", 64'(host_irq_vector), 64'd1);
        ack();
        check("t2_req_dropped", 64'(host_irq_req), 64'd0);
        rd(3'd4);
        idle(2);
        wr(3'd1, 64'hF, 8'h01);
        eoi();

        // Priority and re-request after EOI
        wr(3'd2, 64'hF, 8'h01);
        irq_in = 4'b0101; step();
        irq_in = 4'b0000;
        wait_req("t3a");
        check("t3_vector_first", 64'(host_irq_vector), 64'd0);
        ack();
        wr(3'd1, 64'h1, 8'h01);
        eoi();
        wait_req("t3b");
        check("t3_vector_second", 64'(host_irq_vector), 64'd2);
        ack();
        wr(3'd1, 64'h4, 8'h01);
        eoi();

        // Masking
        wr(3'd2, 64'h0, 8'h01);
        irq_in = 4'b0100; step();
        irq_in = 4'b0000;
        idle(3);
        check("t4_no_req_while_masked", 64'(host_irq_req), 64'd0);
        rd(3'd1); rd(3'd0);
        idle(3);
        wr(3'd2, 64'h4, 8'h01);
        wait_req("t4");
        check("t4_vector", 64'(host_irq_vector), 64'd2);
        ack();
        wr(3'd1, 64'h4, 8'h01);
        eoi();

        // Set / W1C collision, then back-to-back reads
        irq_in = 4'b0010;
        wr(3'd1, 64'h2, 8'h01);
        irq_in = 4'b0000;
        idle(2);
        rd(3'd1);
        for (int a = 0; a < 6; a++) rd(3'(a));
        idle(3);
        wr(3'd1, 64'hF, 8'h01);
        idle(2);

        // Reset while a request is raised
        wr(3'd2, 64'h1, 8'h01);
        irq_in = 4'b0001; step();
        irq_in = 4'b0000;
        wait_req("t6");
        apply_reset();
        rd(3'd1); rd(3'd2);
        idle(3);

        // Held-high line, then W1C
        irq_in = 4'b0001;
        idle(4);
        wr(3'd1, 64'h1, 8'h01);
        idle(3);
        rd(3'd1);
        idle(3);
        irq_in = 4'b0000;
        idle(2);
        wr(3'd1, 64'hF, 8'h01);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            irq_in          = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            avmm_read       = ($urandom_range(0, 2) == 0);
            avmm_write      = ($urandom_range(0, 3) == 0);
            avmm_address    = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 3))
                                                          : 3'($urandom_range(0, 7));
            avmm_writedata  = {$urandom, $urandom};
            avmm_byteenable = 8'($urandom);
            host_irq_ack    = host_irq_req ? ($urandom_range(0, 2) == 0)
                                           : ($urandom_range(0, 9) == 0);
            step();
        end
        irq_in = 4'b0000;
        idle(5);
        check("read_queue_drained", 64'(rq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
